// File: rtl/rpi_irq_scheduler.sv
// Round-robin interrupt scheduler toward the Raspberry Pi interrupt line.
// Define IRQ_TIMEOUT_EN to add the ack timeout and the sticky timeout_err port.
module rpi_irq_scheduler #(
    parameter int N_SRC          = 4,
    parameter int ID_W           = 2,
    parameter int PULSE_CYCLES   = 64,
    parameter int HOLDOFF_CYCLES = 16,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic [N_SRC-1:0] req,
    input  logic             rpi_ack,
    output logic             interrupt_enable,
    output logic [ID_W-1:0]  irq_id,
    output logic [N_SRC-1:0] irq_pending,
    output logic             busy
`ifdef IRQ_TIMEOUT_EN
    ,
    output logic             timeout_err
`endif
);

    localparam int M1 = (PULSE_CYCLES > HOLDOFF_CYCLES) ?
                        PULSE_CYCLES : HOLDOFF_CYCLES;
    localparam int CNT_MAX = (M1 > TIMEOUT_CYCLES) ? M1 : TIMEOUT_CYCLES;
    localparam int CNT_W = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        IDLE,
        ASSERT,
        WAIT_ACK,
        HOLDOFF
    } state_t;

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [ID_W-1:0]    rr_ptr, rr_n;
    logic [ID_W-1:0]    id_n, grant, next_rr;
    logic [N_SRC-1:0]   req_d, pend_n, rot;
    logic               ie_n, busy_n, clr, found;
    logic               ack_s1, ack_s2, ack_s3, ack_evt;
`ifdef IRQ_TIMEOUT_EN
    logic               terr_n;
`endif

    assign ack_evt = ack_s2 & ~ack_s3;
    assign next_rr = ID_W'((int'(irq_id) + 1) % N_SRC);

    // Rotate so bit 0 is the source at rr_ptr; first set bit wins.
    always_comb begin
        rot   = N_SRC'({irq_pending, irq_pending} >> rr_ptr);
        grant = '0;
        found = 1'b0;
        for (int i = 0; i < N_SRC; i++) begin
            if (!found && rot[i]) begin
                grant = ID_W'((int'(rr_ptr) + i) % N_SRC);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt + 1'b1;
        ie_n    = interrupt_enable;
        id_n    = irq_id;
        rr_n    = rr_ptr;
        clr     = 1'b0;
`ifdef IRQ_TIMEOUT_EN
        terr_n  = timeout_err;
`endif
        unique case (state)
            IDLE: begin
                cnt_n = '0;
                if (|irq_pending) begin
                    state_n = ASSERT;
                    id_n    = grant;
                    ie_n    = 1'b1;
                end
            end
            ASSERT: begin
                if (ack_evt) begin
                    ie_n    = 1'b0;
                    clr     = 1'b1;
                    rr_n    = next_rr;
                    cnt_n   = '0;
                    state_n = HOLDOFF;
                end else if (cnt == CNT_W'(PULSE_CYCLES - 1)) begin
                    ie_n    = 1'b0;
                    cnt_n   = '0;
                    state_n = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (ack_evt) begin
                    clr     = 1'b1;
                    rr_n    = next_rr;
                    cnt_n   = '0;
                    state_n = HOLDOFF;
`ifdef IRQ_TIMEOUT_EN
                end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    terr_n  = 1'b1;
                    rr_n    = next_rr;
                    cnt_n   = '0;
                    state_n = HOLDOFF;
                end
`else
                end else begin
                    cnt_n   = cnt;
                end
`endif
            end
            HOLDOFF: begin
                if (cnt == CNT_W'(HOLDOFF_CYCLES - 1)) begin
                    cnt_n   = '0;
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
                ie_n    = 1'b0;
                cnt_n   = '0;
            end
        endcase
        busy_n = (state_n != IDLE);
    end

    // A new edge on the same edge as the completing clear keeps the bit set.
    always_comb begin
        pend_n = irq_pending;
        for (int i = 0; i < N_SRC; i++) begin
            if (clr && irq_id == ID_W'(i)) begin
                pend_n[i] = 1'b0;
            end
        end
        pend_n = pend_n | (req & ~req_d);
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state            <= IDLE;
            cnt              <= '0;
            interrupt_enable <= 1'b0;
            irq_id           <= '0;
            irq_pending      <= '0;
            busy             <= 1'b0;
            rr_ptr           <= '0;
            req_d            <= '0;
            ack_s1           <= 1'b0;
            ack_s2           <= 1'b0;
            ack_s3           <= 1'b0;
        end else begin
            state            <= state_n;
            cnt              <= cnt_n;
            interrupt_enable <= ie_n;
            irq_id           <= id_n;
            irq_pending      <= pend_n;
            busy             <= busy_n;
            rr_ptr           <= rr_n;
            req_d            <= req;
            ack_s1           <= rpi_ack;
            ack_s2           <= ack_s1;
            ack_s3           <= ack_s2;
        end
    end

`ifdef IRQ_TIMEOUT_EN
    always_ff @(posedge clk_in) begin
        if (reset) begin
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= terr_n;
        end
    end
`endif

endmodule

// File: tb/tb_rpi_irq_scheduler.sv
// Directed and randomized bench for rpi_irq_scheduler.
// A grant-level model tracks pending events and the round-robin pointer.
module tb_rpi_irq_scheduler;

    localparam int N     = 4;
    localparam int IDW   = 2;
    localparam int PULSE = 64;
    localparam int HOLD  = 16;
    localparam int TMO   = 100;

    logic           clk_in = 1'b0;
    logic           reset;
    logic [N-1:0]   req;
    logic           rpi_ack;
    logic           interrupt_enable;
    logic [IDW-1:0] irq_id;
    logic [N-1:0]   irq_pending;
    logic           busy;
`ifdef IRQ_TIMEOUT_EN
    logic           timeout_err;
`endif

    int checks = 0;
    int errors = 0;
    bit [N-1:0] pend;
    int rr;

    rpi_irq_scheduler #(
        .N_SRC(N),
        .ID_W(IDW),
        .PULSE_CYCLES(PULSE),
        .HOLDOFF_CYCLES(HOLD),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk_in(clk_in),
        .reset(reset),
        .req(req),
        .rpi_ack(rpi_ack),
        .interrupt_enable(interrupt_enable),
        .irq_id(irq_id),
        .irq_pending(irq_pending),
        .busy(busy)
`ifdef IRQ_TIMEOUT_EN
        ,
        .timeout_err(timeout_err)
`endif
    );

    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Round-robin rule: first pending source at or after rr, wrapping.
    function automatic int pick();
        for (int i = 0; i < N; i++) begin
            if (pend[(rr + i) % N]) return (rr + i) % N;
        end
        return -1;
    endfunction

    task automatic wait_ie();
        int n = 0;
        while (interrupt_enable !== 1'b1 && n < 400) begin
            tick();
            n++;
        end
        chk("ie_rise", 32'(interrupt_enable), 1);
    endtask

    task automatic do_grant(input logic [N-1:0] inj, input int dly);
        int g;
        int w;
        int h;
        logic [N-1:0] m;
        g = pick();
        wait_ie();
        chk("grant_id", 32'(irq_id), g);
        chk("pend_at_grant", 32'(irq_pending), 32'(pend));
        w = 0;
        while (interrupt_enable === 1'b1 && w < 1000) begin
            w++;
            tick();
        end
        chk("pulse_width", w, PULSE);
        m = inj & ~(N'(1) << g);
        if (m != 0) begin
            req  = req | m;
            pend = pend | m;
            tick();
            req  = req & ~m;
        end
        repeat (dly) tick();
        rpi_ack = 1'b1;
        tick();
        rpi_ack = 1'b0;
        tick();
        chk("pend_pre_ack", 32'(irq_pending), 32'(pend));
        tick();
        pend[g] = 1'b0;
        rr = (g + 1) % N;
        chk("pend_post_ack", 32'(irq_pending), 32'(pend));
        chk("busy_holdoff", 32'(busy), 1);
        h = 0;
        while (busy === 1'b1 && h < 1000) begin
            tick();
            h++;
        end
        chk("holdoff_len", h, HOLD);
    endtask

    initial begin
        int g;
        int h;
        int guard;
        bit seen;
        logic [N-1:0] m;
`ifdef IRQ_TIMEOUT_EN
        int t;
        int w;
`endif
        reset   = 1'b1;
        req     = 4'b1111;
        rpi_ack = 1'b0;
        pend    = '0;
        rr      = 0;

        repeat (3) tick();
        chk("rst_ie", 32'(interrupt_enable), 0);
        chk("rst_id", 32'(irq_id), 0);
        chk("rst_pend", 32'(irq_pending), 0);
        chk("rst_busy", 32'(busy), 0);
`ifdef IRQ_TIMEOUT_EN
        chk("rst_terr", 32'(timeout_err), 0);
`endif
        reset = 1'b0;
        pend  = 4'b1111;
        tick();
        chk("rel_pend", 32'(irq_pending), 32'(pend));
        chk("rel_ie", 32'(interrupt_enable), 0);
        for (int i = 0; i < N; i++) do_grant('0, 2);
        req = '0;
        tick();

        req  = 4'b1011;
        pend = pend | 4'b1011;
        tick();
        req = '0;
        do_grant('0, 1);
        do_grant('0, 2);
        do_grant(4'b0101, 3);
        do_grant('0, 1);
        do_grant('0, 1);

        req[2]  = 1'b1;
        pend[2] = 1'b1;
        tick();
        req[2] = 1'b0;
        do_grant('0, 5);

        req[1]  = 1'b1;
        pend[1] = 1'b1;
        tick();
        req[1] = 1'b0;
        g = pick();
        wait_ie();
        chk("early_id", 32'(irq_id), g);
        repeat (10) tick();
        rpi_ack = 1'b1;
        tick();
        rpi_ack = 1'b0;
        tick();
        chk("early_ie_hold", 32'(interrupt_enable), 1);
        tick();
        pend[g] = 1'b0;
        rr = (g + 1) % N;
        chk("early_ie_drop", 32'(interrupt_enable), 0);
        chk("early_busy", 32'(busy), 1);
        chk("early_pend", 32'(irq_pending), 32'(pend));
        req[1]  = 1'b1;
        pend[1] = 1'b1;
        tick();
        req[1] = 1'b0;
        h = 1;
        while (busy === 1'b1 && h < 1000) begin
            tick();
            h++;
        end
        chk("early_holdoff", h, HOLD);
        do_grant('0, 2);

        req[3]  = 1'b1;
        pend[3] = 1'b1;
        do_grant('0, 3);
        seen = 1'b0;
        repeat (900) begin
            tick();
            if (interrupt_enable === 1'b1) seen = 1'b1;
        end
        chk("held_no_regrant", 32'(seen), 0);
        chk("held_pend", 32'(irq_pending), 32'(pend));
        req[3] = 1'b0;
        tick();

        for (int it = 0; it < 6; it++) begin
            m = N'($urandom_range(1, 15));
            req  = m;
            pend = pend | m;
            tick();
            req = '0;
            guard = 0;
            while (pend != 0 && guard < 20) begin
                do_grant(N'($urandom_range(0, 15)), $urandom_range(0, 20));
                guard++;
            end
            guard = 0;
            while (pend != 0 && guard < 8) begin
                do_grant('0, 1);
                guard++;
            end
        end
        chk("rand_drain", 32'(irq_pending), 0);

        req[2] = 1'b1;
        tick();
        req[2] = 1'b0;
        wait_ie();
        repeat (5) tick();
        reset = 1'b1;
        tick();
        chk("midrst_ie", 32'(interrupt_enable), 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_pend", 32'(irq_pending), 0);
        chk("midrst_id", 32'(irq_id), 0);
        reset = 1'b0;
        pend  = '0;
        rr    = 0;
        tick();

`ifdef IRQ_TIMEOUT_EN
        req  = 4'b0011;
        pend = pend | 4'b0011;
        tick();
        req = '0;
        g = pick();
        wait_ie();
        chk("tmo_id", 32'(irq_id), g);
        w = 0;
        while (interrupt_enable === 1'b1 && w < 1000) begin
            w++;
            tick();
        end
        chk("tmo_pulse", w, PULSE);
        t = 0;
        while (timeout_err !== 1'b1 && t < 1000) begin
            tick();
            t++;
        end
        rr = (g + 1) % N;
        chk("tmo_len", t, TMO);
        chk("tmo_busy", 32'(busy), 1);
        chk("tmo_pend", 32'(irq_pending), 32'(pend));
        h = 0;
        while (busy === 1'b1 && h < 1000) begin
            tick();
            h++;
        end
        chk("tmo_holdoff", h, HOLD);
        do_grant('0, 4);
        do_grant('0, 4);
        chk("tmo_sticky", 32'(timeout_err), 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rpi_irq_scheduler.md
Name: rpi_irq_scheduler

Overview:
- Arbitrates interrupt requests from several I2S-side sources (RX half-full, TX half-empty, overrun, etc.) toward the single Raspberry Pi interrupt line.
- Latches request edges as pending bits and grants one source at a time, round-robin.
- Drives the interrupt-clock generator's interrupt_enable for a fixed pulse window, presents the granted source ID, then waits for the Pi's acknowledge before serving the next source.

Parameters:
- N_SRC, 4, number of request sources (2..8).
- ID_W, 2, width of irq_id; must satisfy 2**ID_W >= N_SRC.
- PULSE_CYCLES, 64, clk_in cycles interrupt_enable stays high per grant (1..65535).
- HOLDOFF_CYCLES, 16, idle gap after each grant completes (1..65535).
- TIMEOUT_CYCLES, 50000, ack wait limit; used only with IRQ_TIMEOUT_EN (1..2**20-1).

Ports:
- clk_in  in  1  system clock (50 MHz).
- reset  in  1  synchronous, active-high reset.
- req  in  N_SRC  level requests; a 0->1 transition is one event.
- rpi_ack  in  1  acknowledge from the Pi; asynchronous, synchronised internally.
- interrupt_enable  out  1  enable to the interrupt-clock generator.
- irq_id  out  ID_W  index of the granted source; valid from ASSERT entry to HOLDOFF exit.
- irq_pending  out  N_SRC  current pending vector.
- busy  out  1  high whenever state != IDLE.
- timeout_err  out  1  sticky timeout flag; present only with IRQ_TIMEOUT_EN.

Behaviour:
- All outputs are registered.
- Reset: state=IDLE; interrupt_enable=0, irq_id=0, irq_pending=0, busy=0, timeout_err=0; rr_ptr=0; req_d=0; ack sync flops=0.
- Reset mid-operation aborts any grant. interrupt_enable is 0 on the first edge with reset high. All pending events are discarded.
- Edge capture:
  - req_d <= req every cycle.
  - pending[i] is set at edge k when req[i]=1 and req_d[i]=0 at edge k.
  - A held-high req produces exactly one event.
- Pending clear: pending[g] is cleared when the grant for g completes via ack.
  - If a set and a clear hit the same bit on the same edge, the set wins.
- Ack path:
  - rpi_ack passes through 2 flops, then a third register for edge detect.
  - ack_evt is a 1-cycle pulse, 3 edges after rpi_ack rises.
- Arbitration:
  - In IDLE with pending != 0, pick the first set bit scanning rr_ptr, rr_ptr+1, ... modulo N_SRC.
  - After each grant completes (ack or timeout), rr_ptr <= (g+1) mod N_SRC.
- State machine:
  - IDLE: if pending != 0, go to ASSERT on the next edge; irq_id<=g, interrupt_enable<=1, cnt<=0.
    - Latency: an event captured at edge k gives interrupt_enable=1 after edge k+1.
  - ASSERT: cnt increments each cycle.
    - When cnt reaches PULSE_CYCLES-1: interrupt_enable<=0, go to WAIT_ACK.
    - interrupt_enable is high for exactly PULSE_CYCLES cycles.
    - ack_evt during ASSERT ends the grant early: interrupt_enable<=0, clear pending[g], go to HOLDOFF.
  - WAIT_ACK: interrupt_enable=0, irq_id held.
    - On ack_evt: clear pending[g], go to HOLDOFF.
  - HOLDOFF: counts HOLDOFF_CYCLES cycles, then go to IDLE; irq_id is held until exit.
- ack_evt in IDLE or HOLDOFF is ignored.
- New req events are captured in every state, including during a grant of the same source (that source is re-pended).
- Counters are wide enough for the parameter maxima and never wrap within a state.

Optional Feature:
- Macro: IRQ_TIMEOUT_EN.
- Defined:
  - WAIT_ACK counts cycles. On reaching TIMEOUT_CYCLES without ack_evt: go to HOLDOFF, set timeout_err, advance rr_ptr, leave pending[g] set (it is retried on a later turn).
  - timeout_err stays set until reset.
  - If ack_evt and timeout occur on the same cycle, the ack wins: pending is cleared and timeout_err is not set.
- Not defined: WAIT_ACK waits indefinitely; there is no timeout_err port and no timeout counter.

Test Plan:
- Reset then idle: hold reset 3 cycles with req=4'b1111 → all outputs 0; after release, pending=4'b1111 one edge later and interrupt_enable rises the edge after that with irq_id=0.
- Single grant: req[2] rises, then rpi_ack pulses high 5 cycles after interrupt_enable falls → interrupt_enable high exactly 64 cycles; irq_id=2; pending[2] clears 3 edges after ack rises; busy drops 16 cycles later.
- Round-robin fairness: req=4'b1011 in one cycle with ack each grant → grant order 0,1,3; then a new req[0] event after 3 → next grant 0.
- Early ack plus re-pend: ack during ASSERT of source 1 → interrupt_enable drops within 1 edge of ack_evt, HOLDOFF entered. A req[1] re-rise during HOLDOFF → source 1 granted again after HOLDOFF.
- Held level: req[3] held high 1000 cycles, one ack → exactly one grant; pending[3]=0 afterwards.
- Timeout (IRQ_TIMEOUT_EN, TIMEOUT_CYCLES=100): no ack → after 64+100 cycles go to HOLDOFF; timeout_err=1 and pending[g] still 1. With req=4'b0011 the sequence is 0 (timeout), 1 (ack), 0 (retry).
